// File: rtl/mem_access_unit.sv
// Load/store controller between the CPU and a word-only data memory.
// Sub-word stores are done as read-modify-write; loads extract and extend the addressed lane.
module mem_access_unit #(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsgn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, unsgn_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept_s, acc_err_s;

  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] r;
    r = old_w;
    case (sz)
      2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      2'b10:   r = wd;
      default: r = old_w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract_lane(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = {{24{~uns & b[7]}}, b};
      2'b01:   r = {{16{~uns & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept_s  = (state_q == S_IDLE) && req;
  assign acc_err_s = (size == 2'b11)
                   || ((size == 2'b01) && addr[0])
                   || ((size == 2'b10) && (addr[1:0] != 2'b00))
                   || (addr[31:2] >= 30'(SIZE));

  // State register and captured request fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      unsgn_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      word_q  <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept_s) begin
        we_q    <= we;
        unsgn_q <= unsgn;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (acc_err_s) begin
          state_d = S_DONE;
        end else if (we && (size == 2'b10)) begin
          state_d = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_DONE;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: word capture in RD, status and load result at DONE entry
  always_comb begin
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept_s && acc_err_s) begin
      err_d = 1'b1;
    end else if ((state_q == S_RD) && !we_q) begin
      err_d   = 1'b0;
      rdata_d = extract_lane(mem_rd, size_q, addr_q[1:0], unsgn_q);
    end else if (state_q == S_WR) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (state_q == S_RD) begin
      word_d = mem_rd;
    end else begin
      word_d = word_q;
    end
  end

  // Output decode from state; write enable must never depend on inputs
  always_comb begin
    ready   = 1'b0;
    done    = 1'b0;
    mem_we  = 1'b0;
    mem_adr = 32'h0000_0000;
    mem_wd  = 32'h0000_0000;
    case (state_q)
      S_IDLE: ready = 1'b1;
      S_RD:   mem_adr = {addr_q[31:2], 2'b00};
      S_WR: begin
        mem_adr = {addr_q[31:2], 2'b00};
        mem_we  = 1'b1;
        mem_wd  = merge_word(word_q, wdata_q, size_q, addr_q[1:0]);
      end
      S_DONE: begin
        mem_adr = {addr_q[31:2], 2'b00};
        done    = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model of latency, lanes and memory contents,
// checked against the DUT every cycle, plus literal expectations from the test plan.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n, req, we, unsgn, ready, done, err, mem_we;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, mem_adr, mem_wd, mem_rd;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: k = cycles since acceptance (0 = idle)
  int          k = 0;
  int          lat = 0;
  int          wr_k = 0;
  logic [31:0] exp_adr = 32'h0;
  logic [31:0] exp_wd = 32'h0;
  logic [31:0] model_rdata = 32'h0;
  logic        model_err = 1'b0;

  mem_access_unit #(.SIZE(64)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ready(ready), .we(we), .size(size),
    .unsgn(unsgn), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_adr[31:2] < 30'd64) ? mem[mem_adr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && (mem_adr[31:2] < 30'd64)) mem[mem_adr[7:2]] <= mem_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("ready",   32'(ready),  32'(k == 0));
    chk("done",    32'(done),   32'((k != 0) && (k == lat)));
    chk("mem_we",  32'(mem_we), 32'((k != 0) && (k == wr_k)));
    chk("mem_adr", mem_adr,     (k == 0) ? 32'h0 : exp_adr);
    chk("mem_wd",  mem_wd,      ((k != 0) && (k == wr_k)) ? exp_wd : 32'h0);
    chk("rdata",   rdata,       model_rdata);
    chk("err",     32'(err),    32'(model_err));
  end

  task automatic op(input logic w, input logic [1:0] sz, input logic u,
                    input logic [31:0] a, input logic [31:0] wd, input bit hold);
    logic        e;
    int          idx, nb, sh;
    logic [31:0] old, mask, res, val;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; unsgn = u; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    nb  = 1 << sz;
    idx = int'(a >> 2);
    sh  = 8 * int'(a % 32'd4);
    e   = (sz == 2'd3) || ((a % nb) != 0) || (idx >= 64);
    exp_adr = a & 32'hFFFF_FFFC;
    res = 32'h0;
    val = 32'h0;
    if (e) begin
      lat = 1; wr_k = 0;
    end else if (!w) begin
      lat = 2; wr_k = 0;
    end else if (sz == 2'd2) begin
      lat = 2; wr_k = 1;
    end else begin
      lat = 3; wr_k = 2;
    end
    if (!e) begin
      old = ref_mem[idx];
      if (w) begin
        if (sz == 2'd2) res = wd;
        else begin
          mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
          res  = (old & ~mask) | ((wd << sh) & mask);
        end
        exp_wd = res;
      end else begin
        val = old >> sh;
        if (sz == 2'd0) begin
          val = val & 32'hFF;
          if (!u && val[7]) val = val | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          val = val & 32'hFFFF;
          if (!u && val[15]) val = val | 32'hFFFF_0000;
        end
      end
    end
    k = 1;
    for (int s = 2; s <= lat; s++) begin
      @(posedge clk);
      #1;
      k = s;
    end
    model_err = e;
    if (!e && !w) model_rdata = val;
    if (!e && w) ref_mem[idx] = res;
    @(posedge clk);
    #1;
    k = 0;
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; unsgn = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", rdata, 32'h0);
    reset_n = 1'b1;

    // 1: word store then word load
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    chk("t1_mem", mem[4], 32'hDEADBEEF);
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_err", 32'(err), 32'd0);

    // 2: byte store via RMW, then halfword store
    op(1'b1, 2'b00, 1'b0, 32'h12, 32'h1234565A, 1'b0);
    chk("t2_byte", mem[4], 32'hDE5ABEEF);
    op(1'b1, 2'b01, 1'b0, 32'h10, 32'h00007777, 1'b0);
    chk("t2_half", mem[4], 32'hDE5A7777);

    // 3: sub-word loads with extension
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDE5ABEEF, 1'b0);
    op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
    chk("t3_lb", rdata, 32'hFFFFFFDE);
    op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
    chk("t3_lbu", rdata, 32'h000000DE);
    op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("t3_lh", rdata, 32'hFFFFBEEF);
    op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
    chk("t3_lhu", rdata, 32'h0000DE5A);

    // 4: error cases leave rdata and memory alone
    op(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0);
    chk("t4_half_mis", 32'(err), 32'd1);
    op(1'b1, 2'b10, 1'b0, 32'h102, 32'h55555555, 1'b0);
    chk("t4_word_mis", 32'(err), 32'd1);
    op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0);
    chk("t4_oor", 32'(err), 32'd1);
    op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("t4_rsvd", 32'(err), 32'd1);
    chk("t4_rdata", rdata, 32'h0000DE5A);
    chk("t4_mem", mem[4], 32'hDE5ABEEF);

    // last in-range word
    op(1'b1, 2'b10, 1'b0, 32'hFC, 32'h11223344, 1'b0);
    chk("edge_err", 32'(err), 32'd0);
    op(1'b0, 2'b01, 1'b0, 32'hFE, 32'h0, 1'b0);
    chk("edge_lh", rdata, 32'h00001122);

    // 5: reset during the RD cycle of a byte store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; unsgn = 1'b0; addr = 32'h10; wdata = 32'h000000AB;
    @(posedge clk);
    #1;
    req = 1'b0; exp_adr = 32'h10; lat = 3; wr_k = 2; k = 1;
    #2;
    reset_n = 1'b0;
    k = 0; model_rdata = 32'h0; model_err = 1'b0;
    #1;
    chk("t5_we", 32'(mem_we), 32'd0);
    chk("t5_ready", 32'(ready), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_adr", mem_adr, 32'h0);
    chk("t5_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_mem", mem[4], 32'hDE5ABEEF);

    // 6: req held high across back-to-back loads
    op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    chk("t6_first", rdata, 32'hDE5ABEEF);
    op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0);
    chk("t6_second", rdata, 32'h000000BE);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
